// File: rtl/cfg_cardinfo_loader.sv
// cfg_cardinfo_loader
//   After reset, fetches the 14-byte card-info record (magic, subsystem ID,
//   subsystem vendor ID, DSN, checksum) over a byte-wide request/ack read port.
//   The record is validated by magic byte and an 8-bit zero-sum checksum.
//   The result drives the card-specific read-only config fields. If the record
//   is corrupt, parameter defaults are driven instead. A timeout leaves the
//   current field values untouched.
//
// Ports
//   clock, reset_n                 clock, async active-low reset
//   reload                         one-cycle pulse, restarts the load (DONE only)
//   rd_req / rd_addr               byte read request (level) and byte address
//   rd_ack / rd_data               read complete, data valid in the ack cycle
//   ro_csh_subsystem_id            to f0/f1 subsystem ID field
//   ro_csh_subsystem_vendor_id     to f0/f1 subsystem vendor ID field
//   ro_dsn_serial_number           to f0 DSN field
//   cardinfo_ready                 fields are final
//   cardinfo_status                00 loading, 01 ok, 10 bad record, 11 timeout
`timescale 1ns/1ps
module cfg_cardinfo_loader #(
  parameter logic [15:0] BASE_ADDR      = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] DEF_SUBSYS_ID  = 16'h0666,
  parameter logic [15:0] DEF_SUBSYS_VID = 16'h1014,
  parameter logic [63:0] DEF_DSN        = 64'hDEAD_DEAD_DEAD_DEAD
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        reload,
  output logic        rd_req,
  output logic [15:0] rd_addr,
  input  logic        rd_ack,
  input  logic [7:0]  rd_data,
  output logic [15:0] ro_csh_subsystem_id,
  output logic [15:0] ro_csh_subsystem_vendor_id,
  output logic [63:0] ro_dsn_serial_number,
  output logic        cardinfo_ready,
  output logic [1:0]  cardinfo_status
);

  localparam logic [2:0]  S_IDLE  = 3'd0;
  localparam logic [2:0]  S_REQ   = 3'd1;
  localparam logic [2:0]  S_GAP   = 3'd2;
  localparam logic [2:0]  S_CHECK = 3'd3;
  localparam logic [2:0]  S_DONE  = 3'd4;

  localparam logic [15:0] WAIT_LIM = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  LAST_IDX = 4'd13;
  localparam logic [7:0]  MAGIC    = 8'hCA;

  logic [2:0]   state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   sum_q, sum_d;
  logic [15:0]  wait_q, wait_d;
  // Bytes 0..12 shifted in MSB first: [103:96] magic, [95:80] subsys ID,
  // [79:64] vendor ID, [63:0] DSN. The checksum byte only feeds the sum.
  logic [103:0] shadow_q, shadow_d;
  logic [15:0]  sid_q, sid_d;
  logic [15:0]  vid_q, vid_d;
  logic [63:0]  dsn_q, dsn_d;
  logic [1:0]   status_q, status_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    wait_d   = wait_q;
    shadow_d = shadow_q;
    sid_d    = sid_q;
    vid_d    = vid_q;
    dsn_d    = dsn_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        idx_d   = 4'd0;
        sum_d   = 8'd0;
        wait_d  = 16'd0;
      end
      S_REQ: begin
        // An ack wins over a timeout that expires in the same cycle.
        if (rd_ack) begin
          if (idx_q != LAST_IDX) shadow_d = {shadow_q[95:0], rd_data};
          sum_d   = sum_q + rd_data;
          wait_d  = 16'd0;
          state_d = S_GAP;
        end else if (wait_q == WAIT_LIM) begin
          status_d = 2'b11;
          state_d  = S_DONE;
        end else if (wait_q != 16'hFFFF) begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_GAP: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_CHECK;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_REQ;
        end
      end
      S_CHECK: begin
        if (shadow_q[103:96] == MAGIC && sum_q == 8'd0) begin
          sid_d    = shadow_q[95:80];
          vid_d    = shadow_q[79:64];
          dsn_d    = shadow_q[63:0];
          status_d = 2'b01;
        end else begin
          sid_d    = DEF_SUBSYS_ID;
          vid_d    = DEF_SUBSYS_VID;
          dsn_d    = DEF_DSN;
          status_d = 2'b10;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (reload) begin
          status_d = 2'b00;
          idx_d    = 4'd0;
          sum_d    = 8'd0;
          wait_d   = 16'd0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= 4'd0;
      sum_q    <= 8'd0;
      wait_q   <= 16'd0;
      shadow_q <= '0;
      sid_q    <= DEF_SUBSYS_ID;
      vid_q    <= DEF_SUBSYS_VID;
      dsn_q    <= DEF_DSN;
      status_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      wait_q   <= wait_d;
      shadow_q <= shadow_d;
      sid_q    <= sid_d;
      vid_q    <= vid_d;
      dsn_q    <= dsn_d;
      status_q <= status_d;
    end
  end

  assign rd_req                     = (state_q == S_REQ);
  assign rd_addr                    = BASE_ADDR + {12'd0, idx_q};
  assign cardinfo_ready             = (state_q == S_DONE);
  assign cardinfo_status            = status_q;
  assign ro_csh_subsystem_id        = sid_q;
  assign ro_csh_subsystem_vendor_id = vid_q;
  assign ro_dsn_serial_number       = dsn_q;

endmodule

// File: doc/cfg_cardinfo_loader.md
Name: cfg_cardinfo_loader

Overview:
- Reads the card-specific configuration record (subsystem ID, subsystem vendor ID, device serial number) from a byte-wide VPD/flash read port after reset.
- Validates the record with a magic byte and a checksum, then drives the f0/f1 card-specific read-only config fields into cfg_func0/cfg_func1 in place of fixed tie-offs.
- Drives parameterised default values whenever the record is absent, corrupt or unreachable.

Parameters:
- BASE_ADDR, 16'h0000, byte address of record byte 0 on the read port
- TIMEOUT_CYCLES, 1024, maximum cycles a single byte request may wait for rd_ack (legal range 2..65535)
- DEF_SUBSYS_ID, 16'h0666, fallback subsystem ID
- DEF_SUBSYS_VID, 16'h1014, fallback subsystem vendor ID
- DEF_DSN, 64'hDEAD_DEAD_DEAD_DEAD, fallback serial number

Ports:
- clock  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- reload  in  1  one-cycle pulse; re-runs the load, honoured only in DONE
- rd_req  out  1  byte read request, level
- rd_addr  out  16  byte address, stable while rd_req=1
- rd_ack  in  1  read complete; rd_data is valid in the same cycle
- rd_data  in  8  returned byte
- ro_csh_subsystem_id  out  16  to f0/f1_ro_csh_subsystem_id
- ro_csh_subsystem_vendor_id  out  16  to f0/f1_ro_csh_subsystem_vendor_id
- ro_dsn_serial_number  out  64  to f0_ro_dsn_serial_number
- cardinfo_ready  out  1  output fields are final
- cardinfo_status  out  2  00 loading, 01 record OK, 10 bad magic/checksum, 11 timeout

Behaviour:
- Reset is asynchronous and active-low. All flops clear on reset_n=0, independent of clock.
- Reset values:
  - rd_req=0, rd_addr=BASE_ADDR
  - the three ro_* outputs = DEF_* values
  - cardinfo_ready=0, cardinfo_status=00
  - FSM in IDLE
- Record layout: 14 bytes at BASE_ADDR+0..13.
  - Byte 0: magic 8'hCA.
  - Bytes 1-2: subsystem ID, MSB first.
  - Bytes 3-4: vendor ID, MSB first.
  - Bytes 5-12: DSN, MSB first.
  - Byte 13: checksum. The 8-bit sum of bytes 0..13, mod 256, must equal 8'h00.
- FSM:
  - IDLE: one cycle after reset release, then go to REQ with index=0.
  - REQ: rd_req=1, rd_addr=BASE_ADDR+index. Wait counter increments each cycle with rd_ack=0.
    - On rd_ack=1: capture rd_data into the shadow register, add it to the running sum, clear the wait counter, drop rd_req next cycle, go to GAP.
    - If the wait counter reaches TIMEOUT_CYCLES-1 with no ack: drop rd_req, go to DONE with status 11.
  - GAP: rd_req=0 for exactly one cycle. If index=13, go to CHECK; otherwise increment index and go to REQ.
  - CHECK (1 cycle):
    - magic==8'hCA and sum==0: load the shadow values into the ro_* outputs, status 01.
    - Otherwise: ro_* keep their DEF_* values, status 10.
    - Go to DONE.
  - DONE: cardinfo_ready=1; outputs held. reload=1 returns to IDLE and clears ready, status, index and sum.
- ro_* outputs never change except in the CHECK→DONE transition or on reset. Shadow bytes are never visible on the outputs mid-load. On reload, outputs retain their previous values until the new CHECK resolves.
- rd_ack is ignored whenever rd_req=0, including a late ack arriving after a timeout.
- Timing:
  - reload outside DONE is ignored.
  - reload in the same cycle as CHECK is ignored.
  - rd_ack in the same cycle the wait counter hits the limit counts as an ack, not a timeout.
- Latency with zero-wait acks (ack in the first REQ cycle): 1 IDLE + 14×(REQ+GAP) + 1 CHECK = 30 cycles from reset release to cardinfo_ready=1.
- Reset asserted mid-load aborts immediately. Outputs return to DEF_*, and the load restarts after release.
- Running sum and checksum arithmetic are 8-bit, wrap-around, no carry out.
- Wait counter width is 16 bits; it saturates and never wraps.

Test Plan:
- Valid record CA 06 66 10 14 01 23 45 67 89 AB CD EF + checksum, zero-wait ack → ready at cycle 30. subsys=16'h0666, vid=16'h1014, dsn=64'h0123_4567_89AB_CDEF, status 01. rd_addr covers BASE_ADDR..+13 in order, with a 1-cycle rd_req gap between bytes.
- Same record with the checksum byte +1 → status 10, ready=1. Outputs 0666/1014/DEAD_DEAD_DEAD_DEAD.
- Magic 8'hCB with an otherwise consistent checksum → status 10, defaults held.
- rd_ack withheld on byte 7 with TIMEOUT_CYCLES=16 → rd_req drops after 16 REQ cycles, status 11, defaults. A later stray rd_ack has no effect.
- Random 0-5 cycle ack delays, then reload with a second valid record (dsn=64'h1) → old values hold until the second CHECK, then update atomically to the new values. reload pulsed mid-load is ignored.
- reset_n pulsed low asynchronously mid-byte 9 → outputs go to DEF_*, rd_req=0 with no clock edge. After release the load restarts from BASE_ADDR and completes normally.
